src_pack_fifo: RTL
==================

Name: src_pack_fifo

Overview:
- Source-side staging buffer directly upstream of the compression-unit copy/fill engines.
- Accepts 32-bit words from the DMA read path and packs pairs into 64-bit entries, each tagged with a last flag.
- Presents the entries as a first-word-fall-through FIFO on the m_src_* interface that the engines consume with an active-low get strobe.

Parameters:
DEPTH_LOG2  4  log2 of FIFO entry count (DEPTH = 16 entries of 65 bits)
AE_THRESH   1  m_src_almost_empty asserted when occupancy <= AE_THRESH
AF_THRESH   2  s_almost_full asserted when free entries <= AF_THRESH

Ports:
wb_clk_i            in   1              system clock, all logic on rising edge
wb_rst_ni           in   1              reset, asynchronous assert, active-low
clr                 in   1              synchronous flush, active-high, for start of a new descriptor
s_putn              in   1              active-low write strobe for s_data
s_data              in   32             input word
s_last              in   1              s_data is final word of transfer
s_full              out  1              FIFO has no free entry
s_almost_full       out  1              free entries <= AF_THRESH
m_src_getn          in   1              active-low pop strobe
m_src               out  64             head entry data
m_src_last          out  1              head entry is final entry of transfer
m_src_empty         out  1              no entry available
m_src_almost_empty  out  1              occupancy <= AE_THRESH
level               out  DEPTH_LOG2+1   current occupancy, 0..DEPTH
ovf                 out  1              sticky: write dropped because FIFO was full
udf                 out  1              sticky: pop requested while empty

Behaviour:
- Reset (wb_rst_ni low, async): write/read pointers 0, level 0, half-valid 0, hold register 0, ovf 0, udf 0.
  - Outputs during reset: m_src_empty 1, m_src_almost_empty 1, s_full 0, s_almost_full 0 (when AF_THRESH < DEPTH), m_src 0, m_src_last 0.
- clr (sync, highest priority): same state as reset on the next edge. A put or get in the same cycle is ignored.
- Put accepted when s_putn = 0 and s_full = 0. A put with s_full = 1 is dropped with no state change and sets ovf.
- Packing: a 32-bit half register plus a half_v flag.
  - half_v = 0, s_last = 0: s_data goes to the hold register, half_v <= 1, no push.
  - half_v = 1: push {s_data, hold} (first word in [31:0]) with last = s_last, half_v <= 0.
  - half_v = 0, s_last = 1: push {32'h0, s_data} with last = 1 (odd-length zero pad).
- s_full depends only on FIFO occupancy (level == DEPTH), including for puts that only load the hold register. This keeps the rule simple and conservative.
- Get accepted when m_src_getn = 0 and level != 0: the read pointer advances.
  - A get while empty is ignored and sets udf.
- FWFT: m_src / m_src_last are driven combinationally from the head entry.
  - A pushed entry is visible the cycle after the push edge (m_src_empty falls one cycle after the push).
  - Consumers may sample m_src in the same cycle they assert m_src_getn low.
- While empty, m_src = 0 and m_src_last = 0 (forced), so no stale last flag can reach a consumer.
- Simultaneous push and pop:
  - Both accepted: level unchanged, pointers both advance.
  - At level 0: only the push takes effect, udf set.
  - At level DEPTH: the put is dropped (ovf) and the pop proceeds.
- Pointers wrap modulo DEPTH. level uses DEPTH_LOG2+1 bits so full and empty are distinct.
- Flags are combinational from registered level: empty = (level == 0), almost_empty = (level <= AE_THRESH), full = (level == DEPTH), almost_full = (DEPTH - level <= AF_THRESH).
- Storage is a register/distributed-RAM array with an asynchronous read of the head location.
- ovf and udf clear only on reset or clr.

Test Plan:
- Reset then put 0x11111111, 0x22222222 (last = 1) → one cycle after the second put: m_src = 0x22222222_11111111, m_src_last = 1, level = 1. getn low one cycle → m_src_empty = 1, m_src = 0.
- Odd transfer: put 0xA, 0xB, 0xC (last on 0xC) → entries 0x0000000B_0000000A (last 0), then 0x00000000_0000000C (last 1).
- Fill: 32 puts with no gets.
  - s_almost_full rises at level 14; s_full rises at level 16.
  - A 33rd and 34th put leave level at 16 and set ovf = 1.
  - Draining 16 gets returns entries in order.
  - m_src_almost_empty is high at level 1 and 0.
- Concurrent push/pop at level 5 for 10 cycles → level stays 5, data order preserved.
  - getn low at level 0 → udf = 1, pointers unchanged.
- Mid-transfer control events:
  - Assert clr with half_v = 1 and level = 3 → next cycle level = 0, empty = 1; the next two puts form a fresh entry with no leftover half.
  - Drive wb_rst_ni low mid-stream asynchronously → all outputs take their reset values before the next clock edge.

Source files
------------

// File: rtl/src_pack_fifo_if.sv
// -----------------------------------------------------------------------------
// src_pack_fifo_if
//
// Purpose: groups the put side (32-bit words from the DMA read path) and the
// get side (64-bit packed entries to the copy/fill engines) of src_pack_fifo.
//
// Handshake semantics (both strobes are active-low, sampled on the rising edge):
//   put : s_putn = 0 offers s_data/s_last. It is taken when s_full = 0;
//         otherwise it is dropped and the sticky ovf flag is raised.
//   get : m_src/m_src_last show the head entry (first-word-fall-through).
//         m_src_getn = 0 pops the head when m_src_empty = 0; a pop while empty
//         is ignored and raises the sticky udf flag.
//
// Modports:
//   slave  - the FIFO itself (consumes strobes, produces data/status)
//   master - the environment driving puts and gets
// -----------------------------------------------------------------------------
interface src_pack_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  s_putn;
    logic [31:0]           s_data;
    logic                  s_last;
    logic                  s_full;
    logic                  s_almost_full;
    logic                  m_src_getn;
    logic [63:0]           m_src;
    logic                  m_src_last;
    logic                  m_src_empty;
    logic                  m_src_almost_empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  ovf;
    logic                  udf;

    modport slave (
        input  s_putn, s_data, s_last, m_src_getn,
        output s_full, s_almost_full, m_src, m_src_last, m_src_empty,
               m_src_almost_empty, level, ovf, udf
    );

    modport master (
        output s_putn, s_data, s_last, m_src_getn,
        input  s_full, s_almost_full, m_src, m_src_last, m_src_empty,
               m_src_almost_empty, level, ovf, udf
    );
endinterface

// File: rtl/src_pack_fifo.sv
// -----------------------------------------------------------------------------
// src_pack_fifo
//
// Purpose: source-side staging buffer ahead of the compression copy/fill
// engines. Packs pairs of 32-bit words into 64-bit entries (first word in the
// low half), tags each entry with a last flag, and presents them as a
// first-word-fall-through FIFO.
//
// Ports:
//   wb_clk_i   - clock, rising edge
//   wb_rst_ni  - asynchronous active-low reset
//   clr        - synchronous flush (start of new descriptor), beats put/get
//   bus        - src_pack_fifo_if.slave: put side, get side, level and
//                sticky ovf/udf status
// -----------------------------------------------------------------------------
module src_pack_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int AE_THRESH  = 1,
    parameter int AF_THRESH  = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              clr,
    src_pack_fifo_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);

    // Entry layout: [64] last, [63:32] second word, [31:0] first word.
    logic [64:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LW-1:0]         level_q;
    logic [31:0]           hold;
    logic                  half_v;
    logic                  ovf_q;
    logic                  udf_q;

    logic                  full;
    logic                  empty;
    logic                  put_req;
    logic                  put_ok;
    logic                  push;
    logic                  get_req;
    logic                  pop;
    logic [64:0]           push_entry;
    logic [64:0]           head;

    assign full    = (level_q == DEPTH_L);
    assign empty   = (level_q == '0);
    assign put_req = ~bus.s_putn;
    // Full is judged on occupancy alone, even for puts that would only load
    // the hold register.
    assign put_ok  = put_req & ~full;
    // A word is pushed when it completes a pair, or when it ends an odd-length
    // transfer on its own (zero-padded upper half).
    assign push    = put_ok & (half_v | bus.s_last);
    assign get_req = ~bus.m_src_getn;
    assign pop     = get_req & ~empty;

    assign push_entry = half_v ? {bus.s_last, bus.s_data, hold}
                               : {bus.s_last, 32'h0, bus.s_data};

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            hold    <= '0;
            half_v  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            hold    <= '0;
            half_v  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (put_ok) begin
                if (half_v) begin
                    half_v <= 1'b0;
                end else if (!bus.s_last) begin
                    hold   <= bus.s_data;
                    half_v <= 1'b1;
                end
            end
            if (put_req && full)  ovf_q <= 1'b1;
            if (get_req && empty) udf_q <= 1'b1;
        end
    end

    // Storage has no reset; empty forcing on the read side hides stale data.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_ni && !clr && push) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

    assign bus.m_src              = empty ? 64'h0 : head[63:0];
    assign bus.m_src_last         = empty ? 1'b0  : head[64];
    assign bus.m_src_empty        = empty;
    assign bus.m_src_almost_empty = (level_q <= AE_L);
    assign bus.s_full             = full;
    assign bus.s_almost_full      = ((DEPTH_L - level_q) <= AF_L);
    assign bus.level              = level_q;
    assign bus.ovf                = ovf_q;
    assign bus.udf                = udf_q;
endmodule
